// File: rtl/esc_decode_if.sv
// Signal bundle between an RC/ESC PWM receiver and its consumer.
// The master side drives the tick and the pin; the slave side (the decoder) returns the decoded pulse.
interface esc_decode_if #(
    parameter int VAL_BITS   = 10,
    parameter int WIDTH_BITS = 12
);
    logic                  tmr_1Mhz;
    logic                  pwm_in;
    logic [VAL_BITS-1:0]   val;
    logic [WIDTH_BITS-1:0] width_us;
    logic                  valid;
    logic                  err;
    logic                  active;

    modport master (
        output tmr_1Mhz, pwm_in,
        input  val, width_us, valid, err, active
    );

    modport slave (
        input  tmr_1Mhz, pwm_in,
        output val, width_us, valid, err, active
    );
endinterface

// File: rtl/esc_decode.sv
// RC/ESC PWM receiver: measures the pin's high time in microseconds and turns it into a
// clamped command value, with a loss-of-signal timeout.
module esc_decode #(
    parameter int VAL_BITS   = 10,
    parameter int WIDTH_BITS = 12,
    parameter int OFFSET_US  = 1000,
    parameter int PULSE_LO   = 500,
    parameter int PULSE_HI   = 2500,
    parameter int TIMEOUT_US = 25000
) (
    input  logic       clk,
    input  logic       rst,
    esc_decode_if.slave bus
);
    localparam int D_W = WIDTH_BITS + 2;
    localparam logic [WIDTH_BITS-1:0] LO_W      = WIDTH_BITS'(PULSE_LO);
    localparam logic [WIDTH_BITS-1:0] HI_W      = WIDTH_BITS'(PULSE_HI);
    localparam logic [15:0]           TMO_W     = 16'(TIMEOUT_US);
    localparam logic signed [D_W-1:0] OFFSET_S  = D_W'(OFFSET_US);
    localparam logic signed [D_W-1:0] VAL_MAX_S = D_W'((1 << VAL_BITS) - 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                  sync_p0, sync_p1, sync_p2;
    logic                  rise, fall;
    logic [WIDTH_BITS-1:0] hi_cnt, hi_nxt;
    logic                  too_long, too_short;
    logic                  hi_clr, hi_inc, acc_d, rej_d;
    logic [15:0]           tmo_cnt;
    logic [VAL_BITS-1:0]   val_p1;
    logic [WIDTH_BITS-1:0] width_p1;
    logic                  vld_p1, err_p1, active_p1;

    function automatic logic [WIDTH_BITS-1:0] sat_inc_w(input logic [WIDTH_BITS-1:0] x);
        return (x == '1) ? x : x + WIDTH_BITS'(1);
    endfunction

    function automatic logic [15:0] sat_inc_t(input logic [15:0] x);
        return (x == '1) ? x : x + 16'd1;
    endfunction

    // Signed offset removal, then clamp into the unsigned command range.
    function automatic logic [VAL_BITS-1:0] clamp_val(input logic [WIDTH_BITS-1:0] w);
        logic signed [D_W-1:0] d;
        d = $signed({2'b00, w}) - OFFSET_S;
        if (d[D_W-1])
            return '0;
        else if (d > VAL_MAX_S)
            return '1;
        else
            return d[VAL_BITS-1:0];
    endfunction

    // Stage p0..p2: two-flop synchronizer plus one delay for edge detection
    always_ff @(posedge clk) begin
        sync_p0 <= bus.pwm_in;
        sync_p1 <= sync_p0;
        sync_p2 <= sync_p1;
    end

    assign rise      = sync_p1 & ~sync_p2;
    assign fall      = ~sync_p1 & sync_p2;
    assign hi_nxt    = bus.tmr_1Mhz ? sat_inc_w(hi_cnt) : hi_cnt;
    assign too_long  = hi_nxt > HI_W;
    assign too_short = hi_nxt < LO_W;

    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_LOW;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOW: if (!sync_p1) state_nxt = IDLE;
            IDLE:     if (rise)     state_nxt = HIGH;
            HIGH: begin
                if (too_long)
                    state_nxt = WAIT_LOW;
                else if (fall)
                    state_nxt = IDLE;
            end
            default:  state_nxt = WAIT_LOW;
        endcase
    end

    // A pulse that overruns is rejected immediately, even if it falls in the same cycle.
    always_comb begin
        hi_clr = 1'b0;
        hi_inc = 1'b0;
        acc_d  = 1'b0;
        rej_d  = 1'b0;
        case (state)
            IDLE: hi_clr = rise;
            HIGH: begin
                hi_inc = 1'b1;
                if (too_long)
                    rej_d = 1'b1;
                else if (fall) begin
                    if (too_short)
                        rej_d = 1'b1;
                    else
                        acc_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stage p1: registered outputs, pulse counter and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt    <= '0;
            tmo_cnt   <= '0;
            val_p1    <= '0;
            width_p1  <= '0;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
            active_p1 <= 1'b0;
        end else begin
            if (hi_clr)
                hi_cnt <= '0;
            else if (hi_inc)
                hi_cnt <= hi_nxt;

            vld_p1 <= acc_d;
            err_p1 <= rej_d;

            if (acc_d) begin
                width_p1 <= hi_nxt;
                val_p1   <= clamp_val(hi_nxt);
            end

            if (acc_d)
                tmo_cnt <= '0;
            else if (bus.tmr_1Mhz)
                tmo_cnt <= sat_inc_t(tmo_cnt);

            if (acc_d)
                active_p1 <= 1'b1;
            else if (tmo_cnt >= TMO_W)
                active_p1 <= 1'b0;
        end
    end

    assign bus.val      = val_p1;
    assign bus.width_us = width_p1;
    assign bus.valid    = vld_p1;
    assign bus.err      = err_p1;
    assign bus.active   = active_p1;
endmodule

// File: tb/tb_esc_decode.sv
// Bench for esc_decode: fixed vector table, hand-written multi-cycle sequences, and random
// pulses checked against a pulse-width model. The tick period is shortened to keep runs short.
module tb_esc_decode;
    localparam int VB = 10;
    localparam int WB = 12;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    esc_decode_if #(.VAL_BITS(VB), .WIDTH_BITS(WB)) bus();

    esc_decode #(
        .VAL_BITS(VB), .WIDTH_BITS(WB), .OFFSET_US(1000),
        .PULSE_LO(500), .PULSE_HI(2500), .TIMEOUT_US(25000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int w;
        int exp_vld;
        int exp_err;
        int exp_width;
        int exp_val;
    } vec_t;

    vec_t tbl[12];
    int total = 0;
    int bad   = 0;
    int valid_cnt = 0, err_cnt = 0, overlap = 0, dbl = 0;
    logic prev_valid = 1'b0;
    int tick_p = 1;
    int tick_c = 0;
    int m_width = 0, m_val = 0;

    // Tick generator: one strobe every tick_p clocks.
    initial begin
        bus.tmr_1Mhz = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_c >= tick_p - 1) begin
                bus.tmr_1Mhz = 1'b1;
                tick_c = 0;
            end else begin
                bus.tmr_1Mhz = 1'b0;
                tick_c++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.valid) valid_cnt <= valid_cnt + 1;
        if (bus.err) err_cnt <= err_cnt + 1;
        if (bus.valid && bus.err) overlap <= overlap + 1;
        if (bus.valid && prev_valid) dbl <= dbl + 1;
        prev_valid <= bus.valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: the pulse is accepted iff its width lies in [500, 2500] us.
    function automatic int clampv(input int w);
        int d;
        d = w - 1000;
        if (d < 0) return 0;
        if (d > 1023) return 1023;
        return d;
    endfunction

    task automatic model_pulse(input int w, output int ev, output int ee);
        if (w >= 500 && w <= 2500) begin
            ev = 1; ee = 0;
            m_width = w;
            m_val = clampv(w);
        end else begin
            ev = 0; ee = 1;
        end
    endtask

    task automatic do_reset(input logic pin);
        @(negedge clk);
        bus.pwm_in = pin;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_width = 0;
        m_val = 0;
    endtask

    // High time of w ticks: held for w*tick_p clocks, so the tick count is phase-independent.
    task automatic pulse(input int w, input int gap);
        @(negedge clk);
        bus.pwm_in = 1'b1;
        repeat (w * tick_p) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic apply(input string name, input int w, input int ev, input int ee,
                         input int ew, input int evl, input int eact);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        pulse(w, 12);
        chk({name, ".valid"}, valid_cnt - v0, ev);
        chk({name, ".err"}, err_cnt - e0, ee);
        chk({name, ".width_us"}, int'(bus.width_us), ew);
        chk({name, ".val"}, int'(bus.val), evl);
        chk({name, ".active"}, int'(bus.active), eact);
    endtask

    initial begin
        int ev, ee, v0, e0, k, errk, w;
        bit found;
        int lb[6];

        tbl[0]  = '{1500, 1, 0, 1500, 500};
        tbl[1]  = '{1000, 1, 0, 1000, 0};
        tbl[2]  = '{900,  1, 0, 900,  0};
        tbl[3]  = '{2100, 1, 0, 2100, 1023};
        tbl[4]  = '{400,  0, 1, 2100, 1023};
        tbl[5]  = '{500,  1, 0, 500,  0};
        tbl[6]  = '{499,  0, 1, 500,  0};
        tbl[7]  = '{2500, 1, 0, 2500, 1023};
        tbl[8]  = '{2501, 0, 1, 2500, 1023};
        tbl[9]  = '{1001, 1, 0, 1001, 1};
        tbl[10] = '{2023, 1, 0, 2023, 1023};
        tbl[11] = '{2022, 1, 0, 2022, 1022};
        lb = '{0, 1, 511, 512, 1022, 1023};

        bus.pwm_in = 1'b0;
        rst = 1'b1;
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        chk("reset.val", int'(bus.val), 0);
        chk("reset.width_us", int'(bus.width_us), 0);
        chk("reset.valid", int'(bus.valid), 0);
        chk("reset.err", int'(bus.err), 0);
        chk("reset.active", int'(bus.active), 0);

        foreach (tbl[i]) begin
            model_pulse(tbl[i].w, ev, ee);
            apply($sformatf("tbl%0d", i), tbl[i].w, tbl[i].exp_vld, tbl[i].exp_err,
                  tbl[i].exp_width, tbl[i].exp_val, 1);
        end

        // Stuck-long pulse: err must fire while the pin is still high.
        v0 = valid_cnt; e0 = err_cnt; found = 0; errk = 0;
        @(negedge clk);
        bus.pwm_in = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (bus.err && !found) begin
                found = 1;
                errk = c;
            end
        end
        bus.pwm_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("long.err_seen_high", int'(found), 1);
        chk_rng("long.err_time", errk, 2501, 2506);
        chk("long.valid", valid_cnt - v0, 0);
        chk("long.err", err_cnt - e0, 1);
        chk("long.val_held", int'(bus.val), m_val);

        // Pin already high across reset release: that pulse is ignored.
        v0 = valid_cnt; e0 = err_cnt;
        do_reset(1'b1);
        repeat (700) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("prehigh.valid", valid_cnt - v0, 0);
        chk("prehigh.err", err_cnt - e0, 0);

        // 1200 us pulse, then silence until the timeout drops active.
        v0 = valid_cnt;
        model_pulse(1200, ev, ee);
        @(negedge clk);
        bus.pwm_in = 1'b1;
        repeat (1200) @(negedge clk);
        bus.pwm_in = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.valid) found = 1;
        end
        chk("tmo.valid_seen", int'(found), 1);
        chk("tmo.val", int'(bus.val), m_val);
        chk("tmo.active_set", int'(bus.active), 1);
        k = 0;
        while (bus.active && k < 30000) begin
            @(negedge clk);
            k++;
        end
        chk_rng("tmo.drop_time", k, 24999, 25003);
        chk("tmo.val_held", int'(bus.val), 200);
        chk("tmo.width_held", int'(bus.width_us), 1200);
        chk("tmo.valid_count", valid_cnt - v0, 1);
        model_pulse(1800, ev, ee);
        apply("after_tmo", 1800, ev, ee, m_width, m_val, 1);

        // Slower tick: 700 ticks spread over three clocks each.
        tick_p = 3;
        repeat (10) @(negedge clk);
        model_pulse(700, ev, ee);
        apply("tick3", 700, ev, ee, m_width, m_val, 1);
        tick_p = 1;
        repeat (10) @(negedge clk);

        // Loopback of an ESC output: width = 1000 + commanded value.
        foreach (lb[i]) begin
            v0 = valid_cnt;
            model_pulse(1000 + lb[i], ev, ee);
            pulse(1000 + lb[i], 12);
            chk($sformatf("loop%0d.valid", lb[i]), valid_cnt - v0, 1);
            chk_rng($sformatf("loop%0d.val", lb[i]), int'(bus.val), lb[i] - 1, lb[i] + 1);
        end

        // Random widths; the rejects here together stay far below the timeout.
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(2600, 1);
            model_pulse(w, ev, ee);
            apply($sformatf("rnd%0d_w%0d", i, w), w, ev, ee, m_width, m_val, 1);
        end

        chk("never_valid_and_err", overlap, 0);
        chk("valid_single_cycle", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
